// File: rtl/regfile_sb.sv
// Parametrised 2-read/1-write register file with registered reads, write-back
// bypass and a pending-write scoreboard that flags RAW hazards to decode.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREGS    = 2**ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] s1,
    output logic [DATA_W-1:0] s2,
    output logic              hazard,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    // Addresses outside the implemented range, and reg0 in zero-register mode,
    // are never stored, claimed, read back or reported busy.
    function automatic logic is_writable(input logic [ADDR_W-1:0] a);
        logic ok;
        ok = (int'(a) < NREGS);
        if ((ZERO_REG != 0) && (a == '0)) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

    logic [DATA_W-1:0] regs_r [NREGS];
    logic [NREGS-1:0]  pending_r;
    logic [NREGS-1:0]  pending_nxt_s;
    logic [DATA_W-1:0] s1_r, s2_r;
    logic [DATA_W-1:0] s1_nxt_s, s2_nxt_s;
    logic              busy1_s, busy2_s;
    logic              wb_ok_s, claim_ok_s;

    assign wb_ok_s    = wb_en & is_writable(wb_addr);
    assign claim_ok_s = claim_en & is_writable(claim_addr);

    // Scoreboard update, read-data selection with bypass, and busy lookup.
    always_comb begin
        pending_nxt_s = pending_r;
        s1_nxt_s      = '0;
        s2_nxt_s      = '0;
        busy1_s       = 1'b0;
        busy2_s       = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            // Clear first, then set, so a same-cycle claim wins over write-back.
            if (wb_ok_s && (wb_addr == ADDR_W'(i))) begin
                pending_nxt_s[i] = 1'b0;
            end else begin
                pending_nxt_s[i] = pending_nxt_s[i];
            end
            if (claim_ok_s && (claim_addr == ADDR_W'(i))) begin
                pending_nxt_s[i] = 1'b1;
            end else begin
                pending_nxt_s[i] = pending_nxt_s[i];
            end
            if (rs1 == ADDR_W'(i)) begin
                s1_nxt_s = (wb_en && (wb_addr == rs1)) ? wb_data : regs_r[i];
                busy1_s  = pending_r[i] & ~(wb_en & (wb_addr == rs1));
            end else begin
                s1_nxt_s = s1_nxt_s;
            end
            if (rs2 == ADDR_W'(i)) begin
                s2_nxt_s = (wb_en && (wb_addr == rs2)) ? wb_data : regs_r[i];
                busy2_s  = pending_r[i] & ~(wb_en & (wb_addr == rs2));
            end else begin
                s2_nxt_s = s2_nxt_s;
            end
        end
        if (!is_writable(rs1)) begin
            s1_nxt_s = '0;
            busy1_s  = 1'b0;
        end else begin
            s1_nxt_s = s1_nxt_s;
        end
        if (!is_writable(rs2)) begin
            s2_nxt_s = '0;
            busy2_s  = 1'b0;
        end else begin
            s2_nxt_s = s2_nxt_s;
        end
    end

    // Register storage; dropped writes simply match no implemented entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wb_ok_s && (wb_addr == ADDR_W'(i))) begin
                    regs_r[i] <= wb_data;
                end
            end
        end
    end

    // Pending-write bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Read ports capture only when decode presents a valid read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= '0;
            s2_r <= '0;
        end else if (rd_valid) begin
            s1_r <= s1_nxt_s;
            s2_r <= s2_nxt_s;
        end
    end

    assign s1     = s1_r;
    assign s2     = s2_r;
    assign hazard = rd_valid & (busy1_s | busy2_s);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: default configuration plus a
// small 16-bit, 6-register, no-zero-register configuration.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;

    logic        rd_valid, claim_en, wb_en;
    logic [4:0]  rs1, rs2, claim_addr, wb_addr;
    logic [31:0] wb_data, s1, s2;
    logic        hazard;

    logic        b_rd_valid, b_claim_en, b_wb_en;
    logic [2:0]  b_rs1, b_rs2, b_claim_addr, b_wb_addr;
    logic [15:0] b_wb_data, b_s1, b_s2;
    logic        b_hazard;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk(clk), .rst(rst), .rd_valid(rd_valid), .rs1(rs1), .rs2(rs2),
        .s1(s1), .s2(s2), .hazard(hazard), .claim_en(claim_en),
        .claim_addr(claim_addr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .NREGS(6), .ZERO_REG(0)) u_dut_b (
        .clk(clk), .rst(rst), .rd_valid(b_rd_valid), .rs1(b_rs1), .rs2(b_rs2),
        .s1(b_s1), .s2(b_s2), .hazard(b_hazard), .claim_en(b_claim_en),
        .claim_addr(b_claim_addr), .wb_en(b_wb_en), .wb_addr(b_wb_addr), .wb_data(b_wb_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_valid = 1'b0; claim_en = 1'b0; wb_en = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; claim_addr = 5'd0; wb_addr = 5'd0; wb_data = 32'd0;
        b_rd_valid = 1'b0; b_claim_en = 1'b0; b_wb_en = 1'b0;
        b_rs1 = 3'd0; b_rs2 = 3'd0; b_claim_addr = 3'd0; b_wb_addr = 3'd0; b_wb_data = 16'd0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        check("reset_s1", s1, 32'd0);
        check("reset_s2", s2, 32'd0);
        check("reset_hazard", {31'd0, hazard}, 32'd0);
        rst = 1'b0;
        tick();

        // Populate state, then reset between clock edges.
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h0000_0011;
        claim_en = 1'b1; claim_addr = 5'd2;
        tick();
        idle();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            rd_valid = 1'b1; rs1 = 5'(i); rs2 = 5'(i);
            #1;
            check($sformatf("rst_hazard_r%0d", i), {31'd0, hazard}, 32'd0);
            tick();
            check($sformatf("rst_s1_r%0d", i), s1, 32'd0);
            check($sformatf("rst_s2_r%0d", i), s2, 32'd0);
        end
        idle();

        // Basic write then read; reg0 stays zero.
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        tick();
        idle();
        rd_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd0;
        tick();
        check("basic_s1", s1, 32'hDEAD_BEEF);
        check("basic_s2_r0", s2, 32'd0);
        idle();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_1234;
        tick();
        idle();
        rd_valid = 1'b1; rs1 = 5'd0; rs2 = 5'd5;
        tick();
        check("r0_write_dropped", s1, 32'd0);
        check("basic_s2_r5", s2, 32'hDEAD_BEEF);

        // Hold with rd_valid low, no retroactive bypass.
        idle();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0055;
        tick();
        check("hold_s2", s2, 32'hDEAD_BEEF);
        check("hold_s1", s1, 32'd0);

        // Same-cycle write-through bypass with rs1 == rs2.
        idle();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5_A5A5;
        rd_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd7;
        #1;
        check("bypass_hazard", {31'd0, hazard}, 32'd0);
        tick();
        check("bypass_s1", s1, 32'hA5A5_A5A5);
        check("bypass_s2", s2, 32'hA5A5_A5A5);

        // Scoreboard: claim does not affect hazard in its own cycle.
        idle();
        claim_en = 1'b1; claim_addr = 5'd9;
        rd_valid = 1'b1; rs2 = 5'd9;
        #1;
        check("claim_same_cycle_hazard", {31'd0, hazard}, 32'd0);
        tick();
        idle();
        rd_valid = 1'b1; rs2 = 5'd9;
        #1;
        check("sb_hazard_c1", {31'd0, hazard}, 32'd1);
        tick();
        #1;
        check("sb_hazard_c2", {31'd0, hazard}, 32'd1);
        tick();
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0042;
        #1;
        check("sb_wb_resolves", {31'd0, hazard}, 32'd0);
        tick();
        check("sb_s2", s2, 32'h0000_0042);
        wb_en = 1'b0;
        #1;
        check("sb_cleared", {31'd0, hazard}, 32'd0);

        // Claim and write-back collide on r3: claim wins.
        idle();
        claim_en = 1'b1; claim_addr = 5'd3;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0033;
        tick();
        idle();
        rd_valid = 1'b1; rs1 = 5'd3;
        #1;
        check("coll_hazard", {31'd0, hazard}, 32'd1);
        tick();
        check("coll_s1", s1, 32'h0000_0033);
        check("coll_hazard_still", {31'd0, hazard}, 32'd1);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0077;
        #1;
        check("coll_wb_resolves", {31'd0, hazard}, 32'd0);
        tick();
        check("coll_s1_new", s1, 32'h0000_0077);
        wb_en = 1'b0;
        #1;
        check("coll_cleared", {31'd0, hazard}, 32'd0);

        // Claims on reg0 are ignored; hazard via rs1 with rd_valid low is masked.
        idle();
        claim_en = 1'b1; claim_addr = 5'd0;
        tick();
        claim_addr = 5'd12;
        tick();
        idle();
        rd_valid = 1'b1; rs1 = 5'd0;
        #1;
        check("r0_claim_ignored", {31'd0, hazard}, 32'd0);
        rd_valid = 1'b0; rs1 = 5'd12;
        #1;
        check("hazard_needs_valid", {31'd0, hazard}, 32'd0);
        rd_valid = 1'b1;
        #1;
        check("hazard_rs1", {31'd0, hazard}, 32'd1);
        tick();
        idle();

        // Small configuration: r0 normal, r6/r7 unimplemented.
        b_wb_en = 1'b1; b_wb_addr = 3'd0; b_wb_data = 16'hBEEF;
        tick();
        idle();
        b_rd_valid = 1'b1; b_rs1 = 3'd0;
        tick();
        check("b_r0_normal", {16'd0, b_s1}, 32'h0000_BEEF);
        idle();
        b_wb_en = 1'b1; b_wb_addr = 3'd7; b_wb_data = 16'h1111;
        tick();
        idle();
        b_rd_valid = 1'b1; b_rs1 = 3'd7; b_rs2 = 3'd0;
        tick();
        check("b_r7_dropped", {16'd0, b_s1}, 32'd0);
        check("b_s2_r0", {16'd0, b_s2}, 32'h0000_BEEF);
        idle();
        b_wb_en = 1'b1; b_wb_addr = 3'd7; b_wb_data = 16'h2222;
        b_rd_valid = 1'b1; b_rs1 = 3'd7;
        tick();
        check("b_r7_no_bypass", {16'd0, b_s1}, 32'd0);
        idle();
        b_claim_en = 1'b1; b_claim_addr = 3'd7;
        tick();
        b_claim_addr = 3'd5;
        tick();
        idle();
        b_rd_valid = 1'b1; b_rs1 = 3'd7;
        #1;
        check("b_r7_never_busy", {31'd0, b_hazard}, 32'd0);
        b_rs2 = 3'd5;
        #1;
        check("b_r5_busy", {31'd0, b_hazard}, 32'd1);
        tick();
        idle();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the pipeline's 2-read/1-write register file, placed between decode (read) and write-back (write).
- Generalises data width, register count and the zero-register mode.
- Adds an asynchronous reset, registered reads with write-back bypass, and a pending-write scoreboard.
- The scoreboard raises a hazard flag so decode can stall on RAW dependencies instead of relying only on forwarding.

Parameters:
- DATA_W, 32: data width of each register.
- ADDR_W, 5: register address width.
- NREGS, 2**ADDR_W: number of implemented registers. Must be ≤ 2**ADDR_W. Addresses ≥ NREGS read 0 and ignore writes and claims.
- ZERO_REG, 1: 1 = register 0 is hardwired to 0 (reads 0; writes and claims ignored). 0 = register 0 is a normal register.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_valid  in  1  decode presents rs1/rs2 this cycle.
- rs1  in  ADDR_W  source register 1.
- rs2  in  ADDR_W  source register 2.
- s1  out  DATA_W  registered read data for rs1.
- s2  out  DATA_W  registered read data for rs2.
- hazard  out  1  combinational: a valid read targets a pending register.
- claim_en  in  1  issued instruction will later write claim_addr.
- claim_addr  in  ADDR_W  destination being claimed.
- wb_en  in  1  write-back strobe.
- wb_addr  in  ADDR_W  write-back destination.
- wb_data  in  DATA_W  write-back data.

Behaviour:
- Reset (async, rst=1): all registers = 0, all pending bits = 0, s1 = s2 = 0. hazard evaluates to 0 because no bit is pending. Reset mid-operation discards in-flight claims and writes that cycle.
- Write: on rising edge with wb_en=1 and wb_addr writable, regs[wb_addr] <= wb_data. Non-writable addresses (reg0 when ZERO_REG=1, or ≥ NREGS) are silently dropped.
- Read, latency 1: on rising edge with rd_valid=1, each sN is updated as follows (priority order):
  - 0 if the address is reg0 with ZERO_REG=1, or ≥ NREGS;
  - else wb_data if wb_en=1 and wb_addr==rsN (write-through bypass, same cycle);
  - else regs[rsN].
- With rd_valid=0, s1/s2 hold their value. No retroactive bypass after capture.
- rs1==rs2 is legal; both outputs receive identical data.
- Scoreboard: one pending bit per register. Per edge:
  - claim_en sets pending[claim_addr].
  - wb_en clears pending[wb_addr].
  - Same address in the same cycle: claim wins, bit stays 1 (a newer writer exists).
  - Claims to non-writable addresses are ignored.
  - Claiming an already-pending register keeps it at 1 (single outstanding writer per register is the pipeline's contract).
- hazard = rd_valid & (busy(rs1) | busy(rs2)), where:
  - busy(r) = pending[r] & ~(wb_en & wb_addr==r);
  - a write-back arriving in the same cycle resolves the hazard via the bypass.
  - Non-writable addresses are never busy.
  - A claim in the same cycle does not affect hazard that cycle.
- When hazard=1, s1/s2 still capture. Decode is responsible for stalling and re-presenting rd_valid.

Test Plan:
- Reset: after asserting rst mid-stream, reads of r1..r31 give s1=s2=0 and hazard=0; pending bits cleared even when asserted between clock edges.
- Basic: write r5=0xDEADBEEF; next cycle rd_valid, rs1=5, rs2=0 -> after 1 edge s1=0xDEADBEEF, s2=0. A write to r0 of 0x1234 still reads 0.
- Bypass: same cycle wb_en, wb_addr=7, wb_data=0xA5A5A5A5 with rd_valid, rs1=rs2=7 -> s1=s2=0xA5A5A5A5 next edge, no hazard.
- Scoreboard: claim r9; next cycle read rs2=9 -> hazard=1. Two cycles later wb r9=0x42 while reading rs2=9 -> hazard=0, s2=0x42.
- Claim/write collision: claim_en and wb_en both on r3 in the same cycle -> pending[3] stays 1, so a following read of r3 gives hazard=1 until the next wb on r3.
- Parameter sweep: DATA_W=16, ADDR_W=3, NREGS=6, ZERO_REG=0:
  - write r0=0xBEEF -> reads 0xBEEF;
  - write r7 -> ignored, reads 0;
  - claim r7 -> never raises hazard.
